// File: rtl/inst_queue_decode_pkg.sv
// Shared RV32I decode constants and types for the instruction queue/decoder.
package inst_queue_decode_pkg;
  localparam int WORD       = 32;
  localparam int REG_IDX    = 5;
  localparam int INST_TY_W  = 3;
  localparam int INST_OPT_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [INST_TY_W-1:0] {
    TYPE_NONE = 3'd0, TYPE_R = 3'd1, TYPE_I = 3'd2, TYPE_S = 3'd3,
    TYPE_B = 3'd4, TYPE_U = 3'd5, TYPE_J = 3'd6
  } inst_ty_e;

  typedef enum logic [INST_OPT_W-1:0] {
    OPT_NOP = 6'd0, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
    OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU,
    OPT_SB, OPT_SH, OPT_SW,
    OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
    OPT_SLLI, OPT_SRLI, OPT_SRAI,
    OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR,
    OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
  } inst_opt_e;
endpackage

// File: rtl/inst_decode_comb.sv
// Combinational RV32I base decoder; illegal encodings collapse to an all-zero NOP.
module inst_decode_comb
  import inst_queue_decode_pkg::*;
(
  input  logic [WORD-1:0]       inst,
  output logic [INST_TY_W-1:0]  ty,
  output logic [INST_OPT_W-1:0] opt,
  output logic [REG_IDX-1:0]    rd,
  output logic [REG_IDX-1:0]    rs1,
  output logic [REG_IDX-1:0]    rs2,
  output logic [WORD-1:0]       imm,
  output logic                  is_ls,
  output logic                  illegal
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  inst_ty_e   ty_v;
  inst_opt_e  opt_v;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  // Classify format and operation; flag anything outside the base subset.
  always_comb begin
    ty_v    = TYPE_NONE;
    opt_v   = OPT_NOP;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   begin ty_v = TYPE_U; opt_v = OPT_LUI;   end
      OPC_AUIPC: begin ty_v = TYPE_U; opt_v = OPT_AUIPC; end
      OPC_JAL:   begin ty_v = TYPE_J; opt_v = OPT_JAL;   end
      OPC_JALR:  begin ty_v = TYPE_I; opt_v = OPT_JALR;  end
      OPC_BRANCH: begin
        ty_v = TYPE_B;
        case (f3)
          3'd0: opt_v = OPT_BEQ;
          3'd1: opt_v = OPT_BNE;
          3'd4: opt_v = OPT_BLT;
          3'd5: opt_v = OPT_BGE;
          3'd6: opt_v = OPT_BLTU;
          3'd7: opt_v = OPT_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ty_v = TYPE_I;
        case (f3)
          3'd0: opt_v = OPT_LB;
          3'd1: opt_v = OPT_LH;
          3'd2: opt_v = OPT_LW;
          3'd4: opt_v = OPT_LBU;
          3'd5: opt_v = OPT_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ty_v = TYPE_S;
        case (f3)
          3'd0: opt_v = OPT_SB;
          3'd1: opt_v = OPT_SH;
          3'd2: opt_v = OPT_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        ty_v = TYPE_I;
        case (f3)
          3'd0: opt_v = OPT_ADDI;
          3'd1: begin
            if (f7 == F7_BASE) opt_v = OPT_SLLI;
            else               illegal = 1'b1;
          end
          3'd2: opt_v = OPT_SLTI;
          3'd3: opt_v = OPT_SLTIU;
          3'd4: opt_v = OPT_XORI;
          3'd5: begin
            if (f7 == F7_BASE)     opt_v = OPT_SRLI;
            else if (f7 == F7_ALT) opt_v = OPT_SRAI;
            else                   illegal = 1'b1;
          end
          3'd6: opt_v = OPT_ORI;
          3'd7: opt_v = OPT_ANDI;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        ty_v = TYPE_R;
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: opt_v = OPT_ADD;
            3'd1: opt_v = OPT_SLL;
            3'd2: opt_v = OPT_SLT;
            3'd3: opt_v = OPT_SLTU;
            3'd4: opt_v = OPT_XOR;
            3'd5: opt_v = OPT_SRL;
            3'd6: opt_v = OPT_OR;
            3'd7: opt_v = OPT_AND;
            default: illegal = 1'b1;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            3'd0: opt_v = OPT_SUB;
            3'd5: opt_v = OPT_SRA;
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ty_v  = TYPE_NONE;
      opt_v = OPT_NOP;
    end else begin
      ty_v  = ty_v;
      opt_v = opt_v;
    end
  end

  // Field extraction keyed on the final format, so illegal words yield zeros.
  always_comb begin
    rd  = 5'd0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    imm = 32'd0;
    case (ty_v)
      TYPE_R: begin rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20]; end
      TYPE_I: begin
        rd  = inst[11:7];
        rs1 = inst[19:15];
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      TYPE_S: begin
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      TYPE_B: begin
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      TYPE_U: begin rd = inst[11:7]; imm = {inst[31:12], 12'd0}; end
      TYPE_J: begin
        rd  = inst[11:7];
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: imm = 32'd0;
    endcase
  end

  assign ty    = ty_v;
  assign opt   = opt_v;
  assign is_ls = !illegal && ((opcode == OPC_LOAD) || (opcode == OPC_STORE));
endmodule

// File: rtl/inst_queue_decode.sv
// Fetch-to-dispatch instruction ring buffer feeding a registered decode slot.
module inst_queue_decode
  import inst_queue_decode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [WORD-1:0]       if_pc,
  input  logic [WORD-1:0]       if_inst,
  output logic                  if_ready,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [WORD-1:0]       dec_pc,
  output logic [INST_TY_W-1:0]  dec_ty,
  output logic [INST_OPT_W-1:0] dec_opt,
  output logic [REG_IDX-1:0]    dec_rd,
  output logic [REG_IDX-1:0]    dec_rs1,
  output logic [REG_IDX-1:0]    dec_rs2,
  output logic [WORD-1:0]       dec_imm,
  output logic                  dec_is_ls,
  output logic                  dec_illegal,
  output logic [PTR_W:0]        count
);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WORD-1:0]       pc_mem   [DEPTH];
  logic [WORD-1:0]       inst_mem [DEPTH];
  logic [PTR_W:0]        head;
  logic [PTR_W:0]        tail;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  advance;
  logic [INST_TY_W-1:0]  h_ty;
  logic [INST_OPT_W-1:0] h_opt;
  logic [REG_IDX-1:0]    h_rd;
  logic [REG_IDX-1:0]    h_rs1;
  logic [REG_IDX-1:0]    h_rs2;
  logic [WORD-1:0]       h_imm;
  logic                  h_is_ls;
  logic                  h_illegal;

  // The wrap bit distinguishes full from empty when the index bits match.
  assign empty    = (head == tail);
  assign if_ready = (count != CNT_FULL);
  assign push     = rdy && !flush && if_valid && if_ready;
  assign advance  = rdy && !flush && (!dec_valid || dec_ready);
  assign pop      = advance && !empty;

  inst_decode_comb u_dec (
    .inst    (inst_mem[head[PTR_W-1:0]]),
    .ty      (h_ty),
    .opt     (h_opt),
    .rd      (h_rd),
    .rs1     (h_rs1),
    .rs2     (h_rs2),
    .imm     (h_imm),
    .is_ls   (h_is_ls),
    .illegal (h_illegal)
  );

  // Storage array write port; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail[PTR_W-1:0]]   <= if_pc;
      inst_mem[tail[PTR_W-1:0]] <= if_inst;
    end
  end

  // Pointers, occupancy and the registered decode slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      dec_valid   <= 1'b0;
      dec_pc      <= 32'd0;
      dec_ty      <= TYPE_NONE;
      dec_opt     <= OPT_NOP;
      dec_rd      <= 5'd0;
      dec_rs1     <= 5'd0;
      dec_rs2     <= 5'd0;
      dec_imm     <= 32'd0;
      dec_is_ls   <= 1'b0;
      dec_illegal <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      dec_valid <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      if (push && !pop)      count <= count + PTR_ONE;
      else if (pop && !push) count <= count - PTR_ONE;
      if (advance) begin
        dec_valid <= !empty;
        if (!empty) begin
          dec_pc      <= pc_mem[head[PTR_W-1:0]];
          dec_ty      <= h_ty;
          dec_opt     <= h_opt;
          dec_rd      <= h_rd;
          dec_rs1     <= h_rs1;
          dec_rs2     <= h_rs2;
          dec_imm     <= h_imm;
          dec_is_ls   <= h_is_ls;
          dec_illegal <= h_illegal;
        end
      end
    end
  end
endmodule
